data_mem_responder: RTL and testbench

- Memory-side responder for the processor's data-memory interface: accepts word load/store requests (address = ALU result, store data, write enable) and returns load data.
- Single-ported word RAM with a programmable wait-state count and a one-cycle ready pulse.
- Flags misaligned or out-of-range accesses.
- Sits between the arm core's memory stage and the data RAM in the top level, replacing the zero-latency combinational memory.

---
 rtl/mem_pkg.sv | 22 ++
 rtl/mem_ram_1p.sv | 24 ++
 rtl/data_mem_responder.sv | 121 ++++++++++++
 tb/tb_data_mem_responder.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types, constants and address check for the data-memory responder
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // Load data returned with an error response
  localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;

  // Word-aligned and inside [base, base + span); the 33-bit end avoids wrap at the top of memory
  function automatic logic addr_legal(input logic [31:0] addr,
                                      input logic [31:0] base,
                                      input logic [32:0] span);
    logic [32:0] w_end;
    w_end = {1'b0, base} + span;
    return (addr[1:0] == 2'b00) && (addr >= base) && ({1'b0, addr} < w_end);
  endfunction

endpackage

// File: rtl/mem_ram_1p.sv
// rtl/mem_ram_1p.sv - single-port word RAM, synchronous write and combinational read
module mem_ram_1p #(
  parameter int DEPTH_WORDS = 64,
  parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] index,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);

  logic [31:0] r_mem [DEPTH_WORDS];

  // Contents survive reset, so the array has no reset branch
  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[index] <= wdata;
    end
  end

  assign rdata = r_mem[index];

endmodule

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - wait-stated data-memory responder with one-cycle ready and error flag
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 64,
  parameter int          WAIT_STATES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        ready,
  output logic [31:0] rdata,
  output logic        err,
  output logic        busy
);

  localparam int          IDX_W    = $clog2(DEPTH_WORDS);
  localparam logic [32:0] SPAN     = 33'(DEPTH_WORDS) << 2;
  localparam logic [3:0]  CNT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  state_e           r_state;
  state_e           w_next;
  logic [3:0]       r_cnt;
  logic [31:0]      r_addr;
  logic [31:0]      r_wdata;
  logic             r_we;
  logic [31:0]      r_rdata_hold;
  logic             w_legal;
  logic             w_ram_we;
  logic [IDX_W-1:0] w_index;
  logic [31:0]      w_ram_rdata;

  // Everything after accept works from the latched request, never the live bus
  assign w_legal  = addr_legal(r_addr, BASE_ADDR, SPAN);
  assign w_index  = IDX_W'((r_addr - BASE_ADDR) >> 2);
  assign w_ram_we = (r_state == RESP) && r_we && w_legal;

  mem_ram_1p #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .IDX_W      (IDX_W)
  ) u_ram (
    .clk  (clk),
    .we   (w_ram_we),
    .index(w_index),
    .wdata(r_wdata),
    .rdata(w_ram_rdata)
  );

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state: accept only from IDLE, RESP always lasts a single cycle
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (req) w_next = (WAIT_STATES > 0) ? WAIT : RESP;
      WAIT:    if (r_cnt == 4'd0) w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Latch the request on accept and count down the wait states
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt   <= 4'd0;
      r_addr  <= 32'h0;
      r_we    <= 1'b0;
      r_wdata <= 32'h0;
    end else if ((r_state == IDLE) && req) begin
      r_addr  <= addr;
      r_we    <= we;
      r_wdata <= wdata;
      r_cnt   <= CNT_LOAD;
    end else if (r_state == WAIT) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  // Remember what was presented in the ready cycle so rdata holds afterwards
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rdata_hold <= 32'h0;
    end else if (r_state == RESP) begin
      r_rdata_hold <= rdata;
    end
  end

  // Outputs: ready/err only in RESP; stores leave rdata at its previous value
  always_comb begin
    ready = 1'b0;
    err   = 1'b0;
    busy  = 1'b0;
    rdata = r_rdata_hold;
    case (r_state)
      WAIT: busy = 1'b1;
      RESP: begin
        ready = 1'b1;
        busy  = 1'b1;
        err   = !w_legal;
        if (!w_legal) begin
          rdata = ERR_DATA;
        end else if (!r_we) begin
          rdata = w_ram_rdata;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - scoreboard bench for data_mem_responder with 2 and 0 wait states
module tb_data_mem_responder;

  localparam int          DEPTH = 64;
  localparam logic [31:0] BASE  = 32'h0000_0000;
  localparam logic [31:0] SPAN  = 32'(DEPTH * 4);

  typedef struct {
    logic        we;
    logic        err;
    logic [31:0] data;
    int          acc_cyc;
    int          rdy_cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req   [2];
  logic        we    [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic        ready [2];
  logic        err   [2];
  logic        busy  [2];
  logic [31:0] rdata [2];

  exp_t        sb  [2][$];
  logic [31:0] mdl [2][DEPTH];
  bit          at_resp [2];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(2), .BASE_ADDR(BASE)) dut_ws2 (
    .clk(clk), .reset(rst_n), .req(req[0]), .we(we[0]), .addr(addr[0]), .wdata(wdata[0]),
    .ready(ready[0]), .rdata(rdata[0]), .err(err[0]), .busy(busy[0])
  );

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(0), .BASE_ADDR(BASE)) dut_ws0 (
    .clk(clk), .reset(rst_n), .req(req[1]), .we(we[1]), .addr(addr[1]), .wdata(wdata[1]),
    .ready(ready[1]), .rdata(rdata[1]), .err(err[1]), .busy(busy[1])
  );

  function automatic int ws_of(input int k);
    return (k == 0) ? 2 : 0;
  endfunction

  function automatic bit legal(input logic [31:0] a);
    return (a[1:0] == 2'b00) && ((a - BASE) < SPAN);
  endfunction

  function automatic logic [31:0] pick_addr();
    case ($urandom_range(0, 9))
      0:       return BASE + (32'($urandom_range(0, DEPTH - 1)) << 2) + 32'($urandom_range(1, 3));
      1:       return BASE + SPAN + (32'($urandom_range(0, 15)) << 2);
      2:       return 32'hFFFF_FFFC;
      default: return BASE + (32'($urandom_range(0, DEPTH - 1)) << 2);
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Drive a request and push its expected response, computed from the memory model
  task automatic issue(input int k, input bit w, input logic [31:0] a, input logic [31:0] d,
                       output int acc);
    exp_t e;
    int   idx;
    e.acc_cyc = at_resp[k] ? cyc + 2 : cyc + 1;
    e.rdy_cyc = e.acc_cyc + ws_of(k);
    e.we      = w;
    e.err     = !legal(a);
    e.data    = 32'h0;
    if (e.err) begin
      e.data = 32'hDEAD_BEEF;
    end else begin
      idx = int'((a - BASE) >> 2);
      if (w) mdl[k][idx] = d;
      else   e.data = mdl[k][idx];
    end
    sb[k].push_back(e);
    acc      = e.acc_cyc;
    req[k]   = 1'b1;
    we[k]    = w;
    addr[k]  = a;
    wdata[k] = d;
    at_resp[k] = 1'b0;
  endtask

  // Wait for ready, scrambling the bus after accept; leaves req high for a back-to-back issue
  task automatic wait_ready(input int k, input int acc);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 40 && !seen; n++) begin
      @(negedge clk);
      if (ready[k]) begin
        seen = 1'b1;
      end else if (cyc >= acc) begin
        we[k]    = 1'($urandom);
        addr[k]  = $urandom;
        wdata[k] = $urandom;
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout dut%0d: got no ready expected ready within 40 cycles", k);
      req[k] = 1'b0;
    end
    at_resp[k] = seen;
  endtask

  task automatic access(input int k, input bit w, input logic [31:0] a, input logic [31:0] d);
    int acc;
    issue(k, w, a, d, acc);
    wait_ready(k, acc);
  endtask

  task automatic gap(input int k, input int n);
    req[k]   = 1'b0;
    we[k]    = 1'($urandom);
    addr[k]  = $urandom;
    wdata[k] = $urandom;
    at_resp[k] = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic run_seq(input int k);
    logic [31:0] ta;
    logic [31:0] td;
    ta = (k == 0) ? 32'h10 : 32'hFC;
    td = (k == 0) ? 32'h1234_5678 : 32'hA5A5_A5A5;
    access(k, 1'b1, ta, td);
    access(k, 1'b0, ta, $urandom);
    gap(k, 1);
    for (int i = 0; i < DEPTH; i++) access(k, 1'b1, BASE + 32'(i * 4), $urandom);
    gap(k, 2);
    access(k, 1'b1, 32'h102, 32'hCAFE_F00D);
    access(k, 1'b0, 32'h100, $urandom);
    access(k, 1'b0, 32'h000, $urandom);
    gap(k, 1);
    for (int i = 0; i < 120; i++) begin
      access(k, 1'($urandom_range(0, 1)), pick_addr(), $urandom);
      if ($urandom_range(0, 2) == 0) gap(k, $urandom_range(1, 3));
    end
    gap(k, 2);
  endtask

  task automatic reset_abort();
    logic [31:0] old;
    int          acc;
    old = mdl[0][8];
    issue(0, 1'b1, BASE + 32'h20, ~old, acc);
    @(negedge clk);
    @(negedge clk);
    #2;
    rst_n  = 1'b0;
    req[0] = 1'b0;
    sb[0].delete();
    sb[1].delete();
    mdl[0][8] = old;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    at_resp[0] = 1'b0;
    @(negedge clk);
    access(0, 1'b0, BASE + 32'h20, $urandom);
    gap(0, 3);
  endtask

  // Monitors: pop and compare on every ready, check busy/err/rdata hold every other cycle
  for (genvar k = 0; k < 2; k++) begin : g_mon
    logic [31:0] last_rd;
    exp_t        e;
    logic        exp_busy;
    always @(negedge clk) begin
      if (!rst_n) begin
        chk($sformatf("dut%0d reset ready", k), 32'(ready[k]), 32'h0);
        chk($sformatf("dut%0d reset err", k), 32'(err[k]), 32'h0);
        chk($sformatf("dut%0d reset busy", k), 32'(busy[k]), 32'h0);
        chk($sformatf("dut%0d reset rdata", k), rdata[k], 32'h0);
        last_rd = 32'h0;
      end else begin
        exp_busy = (sb[k].size() > 0) && (cyc >= sb[k][0].acc_cyc);
        chk($sformatf("dut%0d busy", k), 32'(busy[k]), 32'(exp_busy));
        if (ready[k]) begin
          if (sb[k].size() == 0) begin
            chk($sformatf("dut%0d unexpected ready", k), 32'(ready[k]), 32'h0);
          end else begin
            e = sb[k].pop_front();
            chk($sformatf("dut%0d ready cycle", k), 32'(cyc), 32'(e.rdy_cyc));
            chk($sformatf("dut%0d err", k), 32'(err[k]), 32'(e.err));
            if (e.err || !e.we) last_rd = e.data;
            chk($sformatf("dut%0d rdata", k), rdata[k], last_rd);
          end
        end else begin
          chk($sformatf("dut%0d idle err", k), 32'(err[k]), 32'h0);
          chk($sformatf("dut%0d rdata hold", k), rdata[k], last_rd);
        end
      end
    end
  end

  initial begin
    rst_n    = 1'b0;
    req[0]   = 1'b1;  we[0] = 1'b1;  addr[0] = 32'h10;  wdata[0] = 32'h1234_5678;
    req[1]   = 1'b1;  we[1] = 1'b1;  addr[1] = 32'hFC;  wdata[1] = 32'hA5A5_A5A5;
    at_resp[0] = 1'b0;
    at_resp[1] = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    fork
      run_seq(0);
      run_seq(1);
    join
    reset_abort();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (sb[k].size() != 0) begin
        errors++;
        $display("FAIL dut%0d leftover: got %0d pending responses expected 0", k, sb[k].size());
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
